sync_fifo_prog: RTL and testbench



---
 rtl/sync_fifo_prog_if.sv | 49 ++++
 rtl/sync_fifo_prog.sv | 135 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if
// Bundles the data and status signals of one sync_fifo_prog instance.
//   master : the user side (drives clr, wr_en, wr_data, rd_en; observes status)
//   slave  : the FIFO side (observes requests; drives data and status)
// Instantiate it with the same BITS/SIZE as the FIFO it is bound to.
//   clr             flush request
//   wr_en/wr_data   write request and payload
//   wr_full         level == SIZE
//   wr_almost_full  level >= ALMOST_FULL
//   rd_en           read request (pop)
//   rd_data         read payload
//   rd_valid        rd_data is valid this cycle
//   rd_empty        level == 0
//   rd_almost_empty level <= ALMOST_EMPTY
//   level           occupancy 0..SIZE
//   overflow        sticky: write attempted while full
//   underflow       sticky: read attempted while empty
interface sync_fifo_prog_if #(
  parameter int BITS = 32,
  parameter int SIZE = 16
);
  localparam int LW = $clog2(SIZE + 1);

  logic            clr;
  logic            wr_en;
  logic [BITS-1:0] wr_data;
  logic            wr_full;
  logic            wr_almost_full;
  logic            rd_en;
  logic [BITS-1:0] rd_data;
  logic            rd_valid;
  logic            rd_empty;
  logic            rd_almost_empty;
  logic [LW-1:0]   level;
  logic            overflow;
  logic            underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  wr_full, wr_almost_full, rd_data, rd_valid, rd_empty,
           rd_almost_empty, level, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output wr_full, wr_almost_full, rd_data, rd_valid, rd_empty,
           rd_almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock FIFO of SIZE entries (any SIZE >= 2) of BITS bits, with
// occupancy output, programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a choice of
// registered (FWFT=0) or first-word-fall-through (FWFT=1) read.
// Ports:
//   clk    clock, all logic on rising edge
//   rst_n  synchronous active-low reset (dominates everything)
//   bus    sync_fifo_prog_if slave modport carrying all data/status signals
module sync_fifo_prog #(
  parameter int BITS         = 32,
  parameter int SIZE         = 16,
  parameter int ALMOST_FULL  = SIZE - 2,
  parameter int ALMOST_EMPTY = 2,
  parameter int FWFT         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_prog_if.slave  bus
);
  localparam int LW = $clog2(SIZE + 1);
  localparam int PW = ($clog2(SIZE) < 1) ? 1 : $clog2(SIZE);

  generate
    if (SIZE < 2 || ALMOST_FULL < 1 || ALMOST_FULL > SIZE ||
        ALMOST_EMPTY < 0 || ALMOST_EMPTY > SIZE - 1) begin : g_param_check
      $error("sync_fifo_prog: illegal SIZE/ALMOST_FULL/ALMOST_EMPTY");
    end
  endgenerate

  logic [BITS-1:0] mem [SIZE];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   count_reg;
  logic            overflow_reg;
  logic            underflow_reg;

  logic full;
  logic empty;
  logic wr_acc;
  logic rd_acc;

  // Flags depend on the count register only, never on this cycle's requests.
  assign full  = (count_reg == LW'(SIZE));
  assign empty = (count_reg == '0);

  // Reset and flush suppress acceptance so memory and pointers stay put.
  assign wr_acc = rst_n && !bus.clr && bus.wr_en && !full;
  assign rd_acc = rst_n && !bus.clr && bus.rd_en && !empty;

  assign bus.wr_full         = full;
  assign bus.rd_empty        = empty;
  assign bus.wr_almost_full  = (count_reg >= LW'(ALMOST_FULL));
  assign bus.rd_almost_empty = (count_reg <= LW'(ALMOST_EMPTY));
  assign bus.level           = count_reg;
  assign bus.overflow        = overflow_reg;
  assign bus.underflow       = underflow_reg;

  // Storage is never reset; contents are only meaningful between pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  // Explicit wrap at SIZE-1 so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(SIZE - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(SIZE - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      count_reg <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Error flags look at the raw requests: a rejected attempt is what counts.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.wr_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [BITS-1:0] rd_data_reg;
      logic            rd_valid_reg;

      // rd_data holds its last value when nothing is popped; only reset
      // clears it, a flush only drops rd_valid.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) begin
            rd_data_reg <= mem[rd_ptr_reg];
          end
        end
      end

      assign bus.rd_data  = rd_data_reg;
      assign bus.rd_valid = rd_valid_reg;
    end else begin : g_fwft
      // Head of queue is always presented; rd_en simply advances it.
      assign bus.rd_data  = mem[rd_ptr_reg];
      assign bus.rd_valid = !empty;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
// Drives a standard-read and an FWFT instance (SIZE=5, BITS=8,
// ALMOST_FULL=4, ALMOST_EMPTY=1) with identical stimulus and checks them
// against a queue-based reference model, a hand-derived vector table and
// a few hand-written corner-case sequences.
module tb_sync_fifo_prog;
  localparam int BITS = 8;
  localparam int SIZE = 5;
  localparam int AF   = 4;
  localparam int AE   = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr;
  logic            wr_en;
  logic            rd_en;
  logic [BITS-1:0] wr_data;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // reference model state
  int              q[$];
  bit              m_ovf;
  bit              m_unf;
  bit              m_rdv;
  logic [BITS-1:0] m_rdd;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.BITS(BITS), .SIZE(SIZE)) if0 ();
  sync_fifo_prog_if #(.BITS(BITS), .SIZE(SIZE)) if1 ();

  assign if0.clr = clr;   assign if1.clr = clr;
  assign if0.wr_en = wr_en; assign if1.wr_en = wr_en;
  assign if0.rd_en = rd_en; assign if1.rd_en = rd_en;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;

  sync_fifo_prog #(.BITS(BITS), .SIZE(SIZE), .ALMOST_FULL(AF),
                   .ALMOST_EMPTY(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  sync_fifo_prog #(.BITS(BITS), .SIZE(SIZE), .ALMOST_FULL(AF),
                   .ALMOST_EMPTY(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
    end
  endtask

  // Reference behaviour: a plain queue with sticky error bits.
  task automatic model_step();
    bit is_full, is_empty;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;
    end else if (clr) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rdv = 0;
    end else begin
      is_full  = (q.size() == SIZE);
      is_empty = (q.size() == 0);
      if (wr_en && is_full)  m_ovf = 1;
      if (rd_en && is_empty) m_unf = 1;
      m_rdv = 0;
      if (rd_en && !is_empty) begin
        m_rdd = BITS'(q.pop_front());
        m_rdv = 1;
      end
      if (wr_en && !is_full) q.push_back(int'(wr_data));
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("std_level", 32'(if0.level), n);
    chk("std_full", 32'(if0.wr_full), (n == SIZE));
    chk("std_afull", 32'(if0.wr_almost_full), (n >= AF));
    chk("std_empty", 32'(if0.rd_empty), (n == 0));
    chk("std_aempty", 32'(if0.rd_almost_empty), (n <= AE));
    chk("std_ovf", 32'(if0.overflow), m_ovf);
    chk("std_unf", 32'(if0.underflow), m_unf);
    chk("std_rd_valid", 32'(if0.rd_valid), m_rdv);
    chk("std_rd_data", 32'(if0.rd_data), 32'(m_rdd));
    chk("fwft_level", 32'(if1.level), n);
    chk("fwft_ovf", 32'(if1.overflow), m_ovf);
    chk("fwft_unf", 32'(if1.underflow), m_unf);
    chk("fwft_rd_valid", 32'(if1.rd_valid), (n != 0));
    if (n != 0) chk("fwft_rd_data", 32'(if1.rd_data), q[0] & 32'hFF);
  endtask

  task automatic apply(input logic r, input logic c, input logic w,
                       input logic rd, input logic [BITS-1:0] d);
    @(negedge clk);
    rst_n = r; clr = c; wr_en = w; rd_en = rd; wr_data = d;
    @(posedge clk);
    model_step();
    #1;
    txn++;
    $display("txn %0d rst_n=%b clr=%b wr=%b rd=%b d=%02h level=%0d rd_valid=%b rd_data=%02h",
             txn, r, c, w, rd, d, if0.level, if0.rd_valid, if0.rd_data);
    check_model();
  endtask

  typedef struct {
    logic            r, c, w, rd;
    logic [BITS-1:0] d;
    int              lvl;
    logic            ovf, unf, v;
    logic [BITS-1:0] rdd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic c, logic w, logic rd, logic [BITS-1:0] d,
                              int lvl, logic o, logic u, logic v, logic [BITS-1:0] dd);
    vec_t e;
    e.r = r; e.c = c; e.w = w; e.rd = rd; e.d = d;
    e.lvl = lvl; e.ovf = o; e.unf = u; e.v = v; e.rdd = dd;
    tbl.push_back(e);
  endfunction

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    m_ovf = 0; m_unf = 0; m_rdv = 0; m_rdd = '0;

    // Fill past full, drain past empty, then full/empty with both requests.
    add(0,0,0,0,8'h00, 0,0,0,0,8'h00);
    add(1,0,1,0,8'h11, 1,0,0,0,8'h00);
    add(1,0,1,0,8'h12, 2,0,0,0,8'h00);
    add(1,0,1,0,8'h13, 3,0,0,0,8'h00);
    add(1,0,1,0,8'h14, 4,0,0,0,8'h00);
    add(1,0,1,0,8'h15, 5,0,0,0,8'h00);
    add(1,0,1,0,8'h16, 5,1,0,0,8'h00);
    add(1,0,0,1,8'h00, 4,1,0,1,8'h11);
    add(1,0,0,1,8'h00, 3,1,0,1,8'h12);
    add(1,0,0,1,8'h00, 2,1,0,1,8'h13);
    add(1,0,0,1,8'h00, 1,1,0,1,8'h14);
    add(1,0,0,1,8'h00, 0,1,0,1,8'h15);
    add(1,0,0,1,8'h00, 0,1,1,0,8'h15);
    add(1,0,0,0,8'h00, 0,1,1,0,8'h15);
    add(1,0,1,0,8'h21, 1,1,1,0,8'h15);
    add(1,0,1,0,8'h22, 2,1,1,0,8'h15);
    add(1,0,1,0,8'h23, 3,1,1,0,8'h15);
    add(1,0,1,0,8'h24, 4,1,1,0,8'h15);
    add(1,0,1,0,8'h25, 5,1,1,0,8'h15);
    add(1,0,1,1,8'h26, 4,1,1,1,8'h21);
    add(1,0,0,1,8'h00, 3,1,1,1,8'h22);
    add(1,0,0,1,8'h00, 2,1,1,1,8'h23);
    add(1,0,0,1,8'h00, 1,1,1,1,8'h24);
    add(1,0,0,1,8'h00, 0,1,1,1,8'h25);
    add(1,0,1,1,8'h31, 1,1,1,0,8'h25);
    add(1,0,0,1,8'h00, 0,1,1,1,8'h31);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk("tbl_level", 32'(if0.level), tbl[i].lvl);
      chk("tbl_full", 32'(if0.wr_full), (tbl[i].lvl == 5));
      chk("tbl_afull", 32'(if0.wr_almost_full), (tbl[i].lvl >= 4));
      chk("tbl_empty", 32'(if0.rd_empty), (tbl[i].lvl == 0));
      chk("tbl_aempty", 32'(if0.rd_almost_empty), (tbl[i].lvl <= 1));
      chk("tbl_ovf", 32'(if0.overflow), 32'(tbl[i].ovf));
      chk("tbl_unf", 32'(if0.underflow), 32'(tbl[i].unf));
      chk("tbl_rd_valid", 32'(if0.rd_valid), 32'(tbl[i].v));
      chk("tbl_rd_data", 32'(if0.rd_data), 32'(tbl[i].rdd));
    end

    // Pointer wrap: 4 rounds of 3 in / 3 out on a depth-5 FIFO.
    apply(0, 0, 0, 0, 8'h00);
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int k = 0; k < 3; k++) apply(1, 0, 1, 0, BITS'(8'h40 + rnd * 8 + k));
      for (int k = 0; k < 3; k++) begin
        apply(1, 0, 0, 1, 8'h00);
        chk("wrap_data", 32'(if0.rd_data), 32'h40 + rnd * 8 + k);
      end
      chk("wrap_level", 32'(if0.level), 0);
      chk("wrap_empty", 32'(if0.rd_empty), 1);
    end

    // FWFT: word written into empty FIFO shows without rd_en; pop empties it.
    apply(1, 0, 1, 0, 8'hA5);
    chk("fwft_show_valid", 32'(if1.rd_valid), 1);
    chk("fwft_show_data", 32'(if1.rd_data), 32'hA5);
    apply(1, 0, 0, 1, 8'h00);
    chk("fwft_pop_valid", 32'(if1.rd_valid), 0);

    // clr at level 3 with overflow set, together with a write.
    for (int k = 0; k < 6; k++) apply(1, 0, 1, 0, BITS'(8'h01 + k));
    apply(1, 0, 0, 1, 8'h00);
    apply(1, 0, 0, 1, 8'h00);
    chk("pre_clr_level", 32'(if0.level), 3);
    chk("pre_clr_ovf", 32'(if0.overflow), 1);
    apply(1, 1, 1, 0, 8'h77);
    chk("clr_level", 32'(if0.level), 0);
    chk("clr_empty", 32'(if0.rd_empty), 1);
    chk("clr_ovf", 32'(if0.overflow), 0);
    chk("clr_rd_valid", 32'(if0.rd_valid), 0);
    apply(1, 0, 1, 0, 8'h88);
    apply(1, 0, 0, 1, 8'h00);
    chk("clr_dropped_data", 32'(if0.rd_data), 32'h88);
    chk("clr_dropped_level", 32'(if0.level), 0);

    // Reset mid-burst with requests asserted.
    for (int k = 0; k < 3; k++) apply(1, 0, 1, 0, BITS'(8'h91 + k));
    apply(1, 0, 1, 1, 8'h94);
    apply(1, 0, 1, 0, 8'h95);
    apply(0, 1, 1, 1, 8'h55);
    chk("rst_level", 32'(if0.level), 0);
    chk("rst_empty", 32'(if0.rd_empty), 1);
    chk("rst_rd_data", 32'(if0.rd_data), 0);
    chk("rst_rd_valid", 32'(if0.rd_valid), 0);
    chk("rst_ovf", 32'(if0.overflow), 0);
    chk("rst_fwft_valid", 32'(if1.rd_valid), 0);

    // Randomised traffic with epoch-varying write/read pressure.
    for (int i = 0; i < 1500; i++) begin
      int wp, rp;
      wp = 20 + ((i / 150) % 4) * 20;
      rp = 80 - ((i / 150) % 4) * 20;
      apply(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < wp),
            ($urandom_range(0, 99) < rp),
            BITS'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
